// File: rtl/bcd_seq_converter.sv
// Sequential binary-to-BCD converter (double-dabble, one input bit per clock).
// Valid/ready on both sides; the finished result is held in out_bcd/ovf until
// the consumer takes it.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for in_valid; in_ready high
// SHIFT  | one add-3/shift step per cycle, WIDTH cycles total
// DONE   | result latched; out_valid raised, held until out_ready
module bcd_seq_converter #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WIDTH-1:0]      in_bin,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*DIGITS-1:0]   out_bcd,
   output logic                  ovf,
   output logic                  busy
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int BW = 4 * DIGITS;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t          state;
   logic [WIDTH-1:0] shift_reg;
   logic [BW-1:0]   bcd;
   logic [BW-1:0]   bcd_adj;
   logic [BW-1:0]   bcd_next;
   logic [CW-1:0]   cnt;

   // Add 3 to every digit >= 5 ahead of the shift; the bit leaving the top
   // digit is dropped from the accumulator and only recorded as overflow.
   always_comb begin
      bcd_adj = bcd;
      for (int k = 0; k < DIGITS; k++) begin
         if (bcd[4*k +: 4] >= 4'd5) begin
            bcd_adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
         end
      end
      bcd_next = {bcd_adj[BW-2:0], shift_reg[WIDTH-1]};
   end

   assign in_ready = (state == S_IDLE) && !rst;

   // Controller FSM with registered out_valid/busy/out_bcd/ovf.
   // out_valid is raised one edge after DONE entry so that the first valid
   // cycle follows the accept edge by WIDTH+1 edges.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         shift_reg <= '0;
         bcd       <= '0;
         cnt       <= '0;
         out_bcd   <= '0;
         ovf       <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  shift_reg <= in_bin;
                  bcd       <= '0;
                  ovf       <= 1'b0;
                  cnt       <= CW'(WIDTH - 1);
                  busy      <= 1'b1;
                  state     <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               bcd       <= bcd_next;
               shift_reg <= shift_reg << 1;
               if (bcd_adj[BW-1]) begin
                  ovf <= 1'b1;
               end
               cnt <= cnt - 1'b1;
               if (cnt == '0) begin
                  out_bcd <= bcd_next;
                  state   <= S_DONE;
               end
            end
            S_DONE: begin
               if (!out_valid) begin
                  out_valid <= 1'b1;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_seq_converter.sv
// Scoreboard bench for bcd_seq_converter: default build (8b/3 digits),
// a 2-digit build for overflow, and a 16b/5-digit build for wide inputs.
module tb_bcd_seq_converter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   logic        in_valid, in_ready, out_valid, ovf, busy;
   logic        out_ready = 1'b1;
   logic [7:0]  in_bin;
   logic [11:0] out_bcd;

   logic        in2_valid, in2_ready, out2_valid, ovf2, busy2;
   logic        out2_ready = 1'b1;
   logic [7:0]  in2_bin;
   logic [7:0]  out2_bcd;

   logic        in3_valid, in3_ready, out3_valid, ovf3, busy3;
   logic        out3_ready = 1'b1;
   logic [15:0] in3_bin;
   logic [19:0] out3_bcd;

   bcd_seq_converter #(.WIDTH(8), .DIGITS(3)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_bin(in_bin),
      .out_valid(out_valid), .out_ready(out_ready), .out_bcd(out_bcd), .ovf(ovf), .busy(busy));

   bcd_seq_converter #(.WIDTH(8), .DIGITS(2)) dut_d2 (
      .clk(clk), .rst(rst), .in_valid(in2_valid), .in_ready(in2_ready), .in_bin(in2_bin),
      .out_valid(out2_valid), .out_ready(out2_ready), .out_bcd(out2_bcd), .ovf(ovf2), .busy(busy2));

   bcd_seq_converter #(.WIDTH(16), .DIGITS(5)) dut_w16 (
      .clk(clk), .rst(rst), .in_valid(in3_valid), .in_ready(in3_ready), .in_bin(in3_bin),
      .out_valid(out3_valid), .out_ready(out3_ready), .out_bcd(out3_bcd), .ovf(ovf3), .busy(busy3));

   int tests = 0;
   int fails = 0;
   int n_acc = 0;
   int n_out = 0;
   bit stall = 1'b0;

   logic [12:0] q1[$];
   logic [8:0]  q2[$];
   logic [20:0] q3[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic unexpected(input string name);
      tests++;
      fails++;
      $display("FAIL %s: got output with empty scoreboard, expected none", name);
   endtask

   // Decimal digits of v as packed BCD, with overflow flag on top.
   function automatic logic [20:0] model(input int v, input int digits);
      logic [19:0] b;
      int x;
      b = '0;
      x = v;
      for (int k = 0; k < digits; k++) begin
         b[4*k +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return {x != 0, b};
   endfunction

   // Consumer: random stalls when enabled, otherwise always ready.
   always @(posedge clk) begin
      #2;
      out_ready = stall ? ($urandom_range(0, 2) == 0) : 1'b1;
   end

   // Monitors: every valid cycle is compared against the head of the
   // scoreboard, so a stalled output must stay equal to it; pop on handshake.
   always @(negedge clk) begin
      if (!rst && out_valid) begin
         if (q1.size() == 0) begin
            unexpected("main_out");
         end else begin
            check("main_out_bcd", 32'(out_bcd), 32'(q1[0][11:0]));
            check("main_ovf", 32'(ovf), 32'(q1[0][12]));
            check("main_in_ready_in_done", 32'(in_ready), 32'd0);
            if (out_ready) begin
               void'(q1.pop_front());
               n_out++;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && out2_valid) begin
         if (q2.size() == 0) begin
            unexpected("d2_out");
         end else begin
            check("d2_out_bcd", 32'(out2_bcd), 32'(q2[0][7:0]));
            check("d2_ovf", 32'(ovf2), 32'(q2[0][8]));
            if (out2_ready) void'(q2.pop_front());
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && out3_valid) begin
         if (q3.size() == 0) begin
            unexpected("w16_out");
         end else begin
            check("w16_out_bcd", 32'(out3_bcd), 32'(q3[0][19:0]));
            check("w16_ovf", 32'(ovf3), 32'(q3[0][20]));
            if (out3_ready) void'(q3.pop_front());
         end
      end
   end

   task automatic accept1(input logic [7:0] v);
      int guard;
      logic [20:0] m;
      guard = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_bin   = v;
      while (!in_ready && guard < 1000) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 1000) begin
         check("main_accept_timeout", 32'(guard), 32'd0);
      end
      @(posedge clk);
      m = model(int'(v), 3);
      q1.push_back({m[20], m[11:0]});
      n_acc++;
      #1;
      in_valid = 1'b0;
      in_bin   = 8'($urandom);
   endtask

   // Counts edges from the accept edge to the first out_valid, checking
   // in_ready stays low meanwhile; optionally drives junk on the input side.
   task automatic wait_out1(input bit junk);
      int n;
      bit ir_ok;
      n = 0;
      ir_ok = 1'b1;
      while (n < 100) begin
         @(posedge clk);
         n++;
         #1;
         if (out_valid) break;
         if (in_ready) ir_ok = 1'b0;
         if (junk) begin
            in_valid = 1'($urandom);
            in_bin   = 8'($urandom);
         end
      end
      in_valid = 1'b0;
      check("main_latency", 32'(n), 32'd9);
      check("main_in_ready_low_busy", 32'(ir_ok), 32'd1);
   endtask

   task automatic run2(input logic [7:0] v, input logic [8:0] exp);
      int n;
      @(negedge clk);
      check("d2_in_ready", 32'(in2_ready), 32'd1);
      in2_valid = 1'b1;
      in2_bin   = v;
      @(posedge clk);
      q2.push_back(exp);
      #1 in2_valid = 1'b0;
      n = 0;
      while (n < 100 && !out2_valid) begin
         @(posedge clk);
         n++;
         #1;
      end
      check("d2_latency", 32'(n), 32'd9);
      @(posedge clk);
      #1;
      check("d2_busy_after", 32'(busy2), 32'd0);
   endtask

   task automatic run3(input logic [15:0] v, input logic [20:0] exp);
      int n;
      @(negedge clk);
      check("w16_in_ready", 32'(in3_ready), 32'd1);
      in3_valid = 1'b1;
      in3_bin   = v;
      @(posedge clk);
      q3.push_back(exp);
      #1 in3_valid = 1'b0;
      n = 0;
      while (n < 100 && !out3_valid) begin
         @(posedge clk);
         n++;
         #1;
      end
      check("w16_latency", 32'(n), 32'd17);
      @(posedge clk);
      #1;
      check("w16_busy_after", 32'(busy3), 32'd0);
   endtask

   initial begin
      int guard;
      rst = 1'b1;
      in_valid = 1'b0;  in_bin = '0;
      in2_valid = 1'b0; in2_bin = '0;
      in3_valid = 1'b0; in3_bin = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_out_bcd", 32'(out_bcd), 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);
      check("rst_in_ready_low", 32'(in_ready), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_in_ready_after", 32'(in_ready), 32'd1);

      // Basic vectors with out_ready high; in_ready returns the cycle after the handshake.
      accept1(8'd0);
      wait_out1(1'b0);
      @(posedge clk);
      #1;
      check("hs_out_valid_drop", 32'(out_valid), 32'd0);
      check("hs_in_ready_back", 32'(in_ready), 32'd1);
      accept1(8'd255);
      wait_out1(1'b0);

      // Input-side junk during SHIFT must be ignored.
      accept1(8'd173);
      wait_out1(1'b1);

      // Reset in the fourth SHIFT cycle discards the conversion.
      accept1(8'd200);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      void'(q1.pop_back());
      n_acc--;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_out_bcd", 32'(out_bcd), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_in_ready_low", 32'(in_ready), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("midrst_in_ready", 32'(in_ready), 32'd1);
      accept1(8'd42);
      wait_out1(1'b0);

      // Full sweep with random consumer stalls.
      stall = 1'b1;
      for (int v = 0; v < 256; v++) begin
         accept1(8'(v));
         wait_out1(1'b0);
      end
      guard = 0;
      while (q1.size() > 0 && guard < 1000) begin
         @(posedge clk);
         guard++;
      end
      stall = 1'b0;
      repeat (2) @(posedge clk);
      check("main_result_count", 32'(n_out), 32'(n_acc));

      // Two-digit build: overflow with the lower digits still correct.
      run2(8'd99,  {1'b0, 8'h99});
      run2(8'd200, {1'b1, 8'h00});
      run2(8'd255, {1'b1, 8'h55});

      // Wide build.
      run3(16'd65535, {1'b0, 20'h65535});
      run3(16'd10000, {1'b0, 20'h10000});

      repeat (2) @(posedge clk);
      check("d2_queue_drained", 32'(q2.size()), 32'd0);
      check("w16_queue_drained", 32'(q3.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
